// File: rtl/bg_pixel_fifo_if.sv
// bg_pixel_fifo_if -- tile-row push handshake between the background fetcher
// and the background pixel FIFO.
//
// Signals:
//   push_in         fetcher offers one tile row (8 pixels)
//   push_lo_in      tile row low bit-plane, bit 7 = leftmost pixel
//   push_hi_in      tile row high bit-plane, bit 7 = leftmost pixel
//   push_ready_out  FIFO accepts a push this cycle (qualified by the T-cycle enable)
//
// Modports:
//   master  fetcher side (drives the row, observes ready)
//   slave   FIFO side (observes the row, drives ready)
interface bg_pixel_fifo_if;
  logic       push_in;
  logic [7:0] push_lo_in;
  logic [7:0] push_hi_in;
  logic       push_ready_out;

  modport master (
    output push_in,
    output push_lo_in,
    output push_hi_in,
    input  push_ready_out
  );

  modport slave (
    input  push_in,
    input  push_lo_in,
    input  push_hi_in,
    output push_ready_out
  );
endinterface

// File: rtl/bg_pixel_fifo.sv
// bg_pixel_fifo -- background pixel FIFO for one scanline's Draw phase.
//
// The fetcher pushes 8-pixel tile rows (two bit-planes). Pixels leave one per
// T-cycle. The first SCX[2:0] pixels of a line are dropped silently (fine
// scroll); the rest are palette-mapped through BGP and strobed out one clk
// cycle after the pop that produced them. After X_MAX strobes the line is done
// and the FIFO freezes until the next line_start_in.
//
// Parameters:
//   DEPTH  FIFO capacity in pixels (power of two, >= 16)
//   X_MAX  visible pixels per scanline
//
// Ports:
//   clk_in            system clock, rising edge
//   rst_in            synchronous active-low reset
//   tclk_in           T-cycle enable; gates push, pop and discard
//   line_start_in     one-cycle pulse starting a line (overrides push/pop)
//   SCX_in            scroll X, bits [2:0] sampled on line_start_in
//   BGP_in            background palette, applied at pop time
//   bg_en_in          0 forces shade 0
//   push_if           tile-row push handshake (slave side)
//   pixel_valid_out   one-cycle strobe, pixel_out valid
//   pixel_out         palette-mapped shade, held between strobes
//   X_out             pixels emitted this line
//   line_done_out     X_MAX pixels emitted, held until next line_start_in
//   overflow_err_out  sticky push-while-not-ready flag
//
// Build option:
//   BG_FIFO_OVERFLOW_CHECK_EN  when defined, overflow_err_out is a sticky
//                              detector; otherwise it is tied to 0.
module bg_pixel_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned X_MAX = 160
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            tclk_in,
  input  logic            line_start_in,
  input  logic [7:0]      SCX_in,
  input  logic [7:0]      BGP_in,
  input  logic            bg_en_in,
  bg_pixel_fifo_if.slave  push_if,
  output logic            pixel_valid_out,
  output logic [1:0]      pixel_out,
  output logic [7:0]      X_out,
  output logic            line_done_out,
  output logic            overflow_err_out
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    DISCARD,
    DRAW,
    DONE
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [2:0]         disc_q, disc_d;
  logic [7:0]         x_q, x_d;
  logic [1:0]         pix_q, pix_d;
  logic               pix_valid_q, pix_valid_d;
  logic               done_q, done_d;
  logic [1:0]         mem_q [DEPTH];
  logic [1:0]         mem_d [DEPTH];

  logic               active;
  logic               push_ready;
  logic               push_acc;
  logic               pop;
  logic [1:0]         head;
  logic [7:0]         x_inc;

  // Only the fine-scroll bits of SCX matter here.
  logic               unused_scx;
  assign unused_scx = ^SCX_in[7:3];

  assign active     = (state_q == DISCARD) || (state_q == DRAW);
  assign push_ready = active && (count_q <= CNT_W'(DEPTH - 8));
  assign push_if.push_ready_out = push_ready;

  // line_start_in wins over any push/pop in the same cycle.
  assign push_acc = push_if.push_in && push_ready && tclk_in && !line_start_in;
  assign pop      = tclk_in && active && (count_q != '0) && !line_start_in;
  assign head     = mem_q[rd_ptr_q];
  assign x_inc    = x_q + 8'd1;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    disc_d      = disc_q;
    x_d         = x_q;
    pix_d       = pix_q;
    pix_valid_d = 1'b0;
    done_d      = done_q;

    if (line_start_in) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      x_d      = '0;
      disc_d   = SCX_in[2:0];
      done_d   = 1'b0;
      state_d  = (SCX_in[2:0] != 3'd0) ? DISCARD : DRAW;
    end else begin
      if (push_acc) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(8);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      // Push and pop may coincide: net change +7. Ready guarantees no overflow.
      count_d = count_q
              + (push_acc ? CNT_W'(8) : CNT_W'(0))
              - (pop      ? CNT_W'(1) : CNT_W'(0));

      if (pop) begin
        if (state_q == DISCARD) begin
          disc_d = disc_q - 3'd1;
          if (disc_q <= 3'd1) begin
            state_d = DRAW;
          end
        end else begin
          pix_valid_d = 1'b1;
          pix_d       = bg_en_in ? BGP_in[{head, 1'b0} +: 2] : 2'b00;
          x_d         = x_inc;
          if (x_inc == 8'(X_MAX)) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
    end
  end

  // Tile row unpacked into the ring, leftmost pixel at the write pointer.
  always_comb begin
    mem_d = mem_q;
    if (push_acc) begin
      for (int unsigned i = 0; i < 8; i++) begin
        mem_d[PTR_W'(wr_ptr_q + PTR_W'(i))] =
          {push_if.push_hi_in[3'(7 - i)], push_if.push_lo_in[3'(7 - i)]};
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q     <= IDLE;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      disc_q      <= '0;
      x_q         <= '0;
      pix_q       <= '0;
      pix_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      disc_q      <= disc_d;
      x_q         <= x_d;
      pix_q       <= pix_d;
      pix_valid_q <= pix_valid_d;
      done_q      <= done_d;
    end
  end

  // Storage needs no reset: count=0 makes stale contents unreachable.
  always_ff @(posedge clk_in) begin
    mem_q <= mem_d;
  end

  assign pixel_valid_out = pix_valid_q;
  assign pixel_out       = pix_q;
  assign X_out           = x_q;
  assign line_done_out   = done_q;

`ifdef BG_FIFO_OVERFLOW_CHECK_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (line_start_in) begin
      ovf_d = 1'b0;
    end else if (tclk_in && push_if.push_in && !push_ready && active) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign overflow_err_out = ovf_q;
`else
  assign overflow_err_out = 1'b0;
`endif

endmodule

// File: tb/tb_bg_pixel_fifo.sv
// Directed bench for bg_pixel_fifo: table of single-row lines plus
// hand-written sequences for fine scroll, full line, back-pressure and reset.
module tb_bg_pixel_fifo;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       tclk_in;
  logic       line_start_in;
  logic [7:0] SCX_in;
  logic [7:0] BGP_in;
  logic       bg_en_in;
  logic       pixel_valid_out;
  logic [1:0] pixel_out;
  logic [7:0] X_out;
  logic       line_done_out;
  logic       overflow_err_out;

  bg_pixel_fifo_if ifc ();

  bg_pixel_fifo #(.DEPTH(16), .X_MAX(160)) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .tclk_in          (tclk_in),
    .line_start_in    (line_start_in),
    .SCX_in           (SCX_in),
    .BGP_in           (BGP_in),
    .bg_en_in         (bg_en_in),
    .push_if          (ifc),
    .pixel_valid_out  (pixel_valid_out),
    .pixel_out        (pixel_out),
    .X_out            (X_out),
    .line_done_out    (line_done_out),
    .overflow_err_out (overflow_err_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [1:0] pix;
    logic [7:0] x;
    logic       done;
  } strobe_t;

  strobe_t q[$];

  always @(negedge clk_in) begin
    if (rst_in && pixel_valid_out) q.push_back({pixel_out, X_out, line_done_out});
  end

  typedef struct packed {
    logic [7:0]      lo;
    logic [7:0]      hi;
    logic [7:0]      bgp;
    logic            en;
    logic [0:7][1:0] exp;
  } vec_t;

  vec_t vecs [5];
  int checks = 0;
  int errors = 0;

  `ifdef BG_FIFO_OVERFLOW_CHECK_EN
  localparam int OVF_EXP = 1;
  `else
  localparam int OVF_EXP = 0;
  `endif

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_line_start(input logic [7:0] scx);
    SCX_in = scx;
    line_start_in = 1'b1;
    tick();
    line_start_in = 1'b0;
  endtask

  task automatic push_row(input logic [7:0] lo, input logic [7:0] hi);
    int g = 0;
    while (!ifc.push_ready_out && g < 200) begin
      tick();
      g++;
    end
    if (!ifc.push_ready_out) begin
      check("push_ready_timeout", 0, 1);
    end else begin
      ifc.push_lo_in = lo;
      ifc.push_hi_in = hi;
      ifc.push_in = 1'b1;
      tick();
      ifc.push_in = 1'b0;
    end
  endtask

  task automatic wait_strobes(input int n, input string nm);
    int g = 0;
    while (q.size() < n && g < 600) begin
      tick();
      g++;
    end
    check(nm, int'(q.size() >= n), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int bad;
    int n;
    logic [7:0] lo, hi;
    logic [1:0] c;
    logic [1:0] exp16 [16];
    logic [1:0] exp19 [19];

    // Shade tables below are worked by hand from the bit-planes.
    vecs[0] = '{lo: 8'h0F, hi: 8'h33, bgp: 8'hE4, en: 1'b1,
                exp: {2'd0, 2'd0, 2'd2, 2'd2, 2'd1, 2'd1, 2'd3, 2'd3}};
    vecs[1] = '{lo: 8'h0F, hi: 8'h33, bgp: 8'h1B, en: 1'b1,
                exp: {2'd3, 2'd3, 2'd1, 2'd1, 2'd2, 2'd2, 2'd0, 2'd0}};
    vecs[2] = '{lo: 8'hAA, hi: 8'hCC, bgp: 8'hE4, en: 1'b1,
                exp: {2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0}};
    vecs[3] = '{lo: 8'hFF, hi: 8'hFF, bgp: 8'hE4, en: 1'b0,
                exp: {2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0}};
    vecs[4] = '{lo: 8'h0F, hi: 8'h33, bgp: 8'hFF, en: 1'b1,
                exp: {2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3}};

    rst_in = 1'b0;
    tclk_in = 1'b1;
    line_start_in = 1'b0;
    SCX_in = 8'h00;
    BGP_in = 8'hE4;
    bg_en_in = 1'b1;
    ifc.push_in = 1'b0;
    ifc.push_lo_in = 8'h00;
    ifc.push_hi_in = 8'h00;

    // Reset state
    tick();
    tick();
    check("rst_x", int'(X_out), 0);
    check("rst_valid", int'(pixel_valid_out), 0);
    check("rst_pixel", int'(pixel_out), 0);
    check("rst_done", int'(line_done_out), 0);
    check("rst_ready", int'(ifc.push_ready_out), 0);
    check("rst_ovf", int'(overflow_err_out), 0);
    rst_in = 1'b1;
    tick();
    check("idle_ready", int'(ifc.push_ready_out), 0);

    // Table: one row per line, SCX=0
    for (int v = 0; v < 5; v++) begin
      BGP_in = vecs[v].bgp;
      bg_en_in = vecs[v].en;
      do_line_start(8'h00);
      q.delete();
      push_row(vecs[v].lo, vecs[v].hi);
      wait_strobes(8, $sformatf("vec%0d_strobes", v));
      bad = 0;
      for (int i = 0; i < 8 && i < q.size(); i++) begin
        if (q[i].pix != vecs[v].exp[i] || q[i].x != 8'(i + 1)) bad++;
      end
      check($sformatf("vec%0d_pixels", v), bad, 0);
      tick();
      tick();
      check($sformatf("vec%0d_x", v), int'(X_out), 8);
      check($sformatf("vec%0d_hold", v), int'(pixel_out), int'(vecs[v].exp[7]));
      check($sformatf("vec%0d_nostrobe", v), int'(pixel_valid_out), 0);
    end

    // Fine scroll: SCX=5 drops first five pixels of row 0
    BGP_in = 8'hE4;
    bg_en_in = 1'b1;
    exp19 = '{2'd1, 2'd2, 2'd3,
              2'd0, 2'd0, 2'd2, 2'd2, 2'd1, 2'd1, 2'd3, 2'd3,
              2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1};
    do_line_start(8'h05);
    q.delete();
    push_row(8'h55, 8'h33);
    push_row(8'h0F, 8'h33);
    push_row(8'hFF, 8'h00);
    wait_strobes(19, "scx_strobes");
    if (q.size() > 0) begin
      check("scx_first_pix", int'(q[0].pix), 1);
      check("scx_first_x", int'(q[0].x), 1);
    end
    bad = 0;
    for (int i = 0; i < 19 && i < q.size(); i++) begin
      if (q[i].pix != exp19[i] || q[i].x != 8'(i + 1)) bad++;
    end
    check("scx_order", bad, 0);
    repeat (10) tick();
    check("scx_count", q.size(), 19);

    // Full line: 21 rows offered, only 160 pixels may appear
    BGP_in = 8'h1B;
    do_line_start(8'h00);
    q.delete();
    for (int k = 0; k < 21; k++) push_row(8'(k * 37), 8'(k * 91 + 5));
    wait_strobes(160, "line_strobes");
    repeat (20) tick();
    check("line_no_161", q.size(), 160);
    bad = 0;
    n = (q.size() < 160) ? q.size() : 160;
    for (int s = 0; s < n; s++) begin
      lo = 8'((s / 8) * 37);
      hi = 8'((s / 8) * 91 + 5);
      c = {hi[7 - (s % 8)], lo[7 - (s % 8)]};
      if (q[s].pix != 2'd3 - c || q[s].x != 8'(s + 1)) bad++;
    end
    check("line_order", bad, 0);
    if (q.size() >= 160) begin
      check("line_done_160", int'(q[159].done), 1);
      check("line_done_159", int'(q[158].done), 0);
      check("line_x_160", int'(q[159].x), 160);
    end
    check("line_ready_done", int'(ifc.push_ready_out), 0);
    check("line_done_held", int'(line_done_out), 1);
    ifc.push_in = 1'b1;
    tick();
    ifc.push_in = 1'b0;
    check("done_push_no_ovf", int'(overflow_err_out), 0);
    check("done_x_frozen", int'(X_out), 160);

    // Back-pressure: count 8 push+pop -> 15, then count 9 push rejected
    BGP_in = 8'hE4;
    exp16 = '{2'd0, 2'd0, 2'd2, 2'd2, 2'd1, 2'd1, 2'd3, 2'd3,
              2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    do_line_start(8'h00);
    q.delete();
    ifc.push_lo_in = 8'h0F;
    ifc.push_hi_in = 8'h33;
    ifc.push_in = 1'b1;
    tick();
    ifc.push_in = 1'b0;
    tclk_in = 1'b0;
    check("bp_ready_cnt8", int'(ifc.push_ready_out), 1);
    tick();
    check("bp_tclk_gates_pop", q.size(), 0);
    tclk_in = 1'b1;
    ifc.push_lo_in = 8'h55;
    ifc.push_hi_in = 8'h33;
    ifc.push_in = 1'b1;
    tick();
    ifc.push_in = 1'b0;
    check("bp_ready_cnt15", int'(ifc.push_ready_out), 0);
    repeat (6) tick();
    check("bp_ready_cnt9", int'(ifc.push_ready_out), 0);
    ifc.push_lo_in = 8'hFF;
    ifc.push_hi_in = 8'hFF;
    ifc.push_in = 1'b1;
    tick();
    ifc.push_in = 1'b0;
    check("bp_ovf", int'(overflow_err_out), OVF_EXP);
    repeat (40) tick();
    check("bp_count", q.size(), 16);
    bad = 0;
    for (int i = 0; i < 16 && i < q.size(); i++) begin
      if (q[i].pix != exp16[i]) bad++;
    end
    check("bp_order", bad, 0);
    do_line_start(8'h00);
    check("bp_ovf_cleared", int'(overflow_err_out), 0);

    // Reset mid-line
    do_line_start(8'h00);
    q.delete();
    begin
      int g = 0;
      while (q.size() < 50 && g < 40) begin
        push_row(8'hFF, 8'hFF);
        g++;
      end
    end
    check("rstmid_reached50", int'(q.size() >= 50), 1);
    rst_in = 1'b0;
    line_start_in = 1'b1;
    ifc.push_in = 1'b1;
    tick();
    tick();
    line_start_in = 1'b0;
    ifc.push_in = 1'b0;
    check("rstmid_x", int'(X_out), 0);
    check("rstmid_pixel", int'(pixel_out), 0);
    check("rstmid_valid", int'(pixel_valid_out), 0);
    check("rstmid_ready", int'(ifc.push_ready_out), 0);
    rst_in = 1'b1;
    q.delete();
    repeat (10) tick();
    check("rstmid_no_strobe", q.size(), 0);
    do_line_start(8'h00);
    check("rstmid_empty_ready", int'(ifc.push_ready_out), 1);
    push_row(8'h0F, 8'h33);
    wait_strobes(8, "rstmid_resume");
    bad = 0;
    for (int i = 0; i < 8 && i < q.size(); i++) begin
      if (q[i].pix != vecs[0].exp[i] || q[i].x != 8'(i + 1)) bad++;
    end
    check("rstmid_pixels", bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
